// File: rtl/mitll_dfft_deser.sv
`default_nettype none
// ============================================================================
// Module      : mitll_dfft_deser
// Description : Capture stage behind the mitll_dfft cell. Each SFQ pulse on
//               the DFF output is a level toggle. Pulses are turned back into
//               bits, one per enabled clock, and packed LSB-first into
//               WIDTH-bit words. Completed words go through a 2-entry FIFO
//               with a valid/ready handshake. A saturating counter tracks
//               every detected pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mitll_dfft_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             en,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overflow,
    output logic [CNT_W-1:0] pulse_cnt
);

    localparam int                 c_idx_w   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(WIDTH - 1);
    localparam logic [CNT_W-1:0]   c_cnt_max = '1;

    logic               r_din_q;
    logic [c_idx_w-1:0] r_idx;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_mem [2];
    logic               r_rptr;
    logic               r_wptr;
    logic [1:0]         r_count;

    logic               w_p;
    logic [WIDTH-1:0]   w_word;
    logic               w_done;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // A toggle of the DFF output since the previous edge is one pulse.
    assign w_p = din ^ r_din_q;

    // Bits at and above r_idx are always zero, so the new bit is simply ORed in.
    assign w_word = r_shift | ({{(WIDTH-1){1'b0}}, w_p} << r_idx);
    assign w_done = en && (r_idx == c_last);

    // FIFO status and handshake; pop is only possible when something is held.
    assign dout_valid = (r_count != 2'd0);
    assign w_full     = (r_count == 2'd2);
    assign w_pop      = dout_valid && dout_ready;
    assign w_push     = w_done && (!w_full || w_pop);
    assign w_drop     = w_done && w_full && !w_pop;
    assign dout       = r_mem[r_rptr];

    // Edge history and word assembly; reset captures din so release is glitch-free.
    always_ff @(posedge clk) begin
        r_din_q <= din;
        if (!rst_n) begin
            r_idx   <= '0;
            r_shift <= '0;
        end else if (en) begin
            if (r_idx == c_last) begin
                r_idx   <= '0;
                r_shift <= '0;
            end else begin
                r_idx   <= r_idx + 1'b1;
                r_shift <= w_word;
            end
        end
    end

    // Saturating pulse counter, independent of the sampling enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
        end else if (w_p && (pulse_cnt != c_cnt_max)) begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

    // Two-entry FIFO with sticky overflow on a dropped completed word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rptr   <= 1'b0;
            r_wptr   <= 1'b0;
            r_count  <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mitll_dfft_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_mitll_dfft_deser
// Description : Directed self-checking bench for mitll_dfft_deser. A second
//               instance with a 4-bit counter shares the stimulus to show
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mitll_dfft_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b1;
    logic       en = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       overflow;
    logic [15:0] pulse_cnt;
    logic [7:0] dout4;
    logic       dout_valid4;
    logic       overflow4;
    logic [3:0] pulse_cnt4;

    int passed = 0;
    int total  = 0;

    mitll_dfft_deser #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .dout_ready(dout_ready),
        .dout(dout), .dout_valid(dout_valid), .overflow(overflow), .pulse_cnt(pulse_cnt)
    );

    mitll_dfft_deser #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .en(en), .dout_ready(dout_ready),
        .dout(dout4), .dout_valid(dout_valid4), .overflow(overflow4), .pulse_cnt(pulse_cnt4)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Optionally toggle din (one pulse) ahead of the next edge, then clock.
    task automatic tick(input bit t);
        if (t) din = ~din;
        step();
    endtask

    // Clock one 8-bit word: bit i of pat set means a pulse lands on that edge.
    task automatic word(input logic [7:0] pat);
        for (int i = 0; i < 8; i++) tick(pat[i]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        // Reset with din held high; release must not create a pulse.
        step();
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'h00);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(pulse_cnt), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("quiet_not_yet", 32'(dout_valid), 32'd0);
        step();
        chk("quiet_valid", 32'(dout_valid), 32'd1);
        chk("quiet_dout", 32'(dout), 32'h00);
        chk("quiet_cnt", 32'(pulse_cnt), 32'd0);
        en = 1'b0;
        dout_ready = 1'b1;
        step();
        chk("quiet_popped", 32'(dout_valid), 32'd0);

        // Pulses on edges 0, 2, 7 give 0x85, visible for a single cycle.
        en = 1'b1;
        word(8'h85);
        chk("w85_valid", 32'(dout_valid), 32'd1);
        chk("w85_dout", 32'(dout), 32'h85);
        chk("w85_cnt", 32'(pulse_cnt), 32'd3);
        en = 1'b0;
        step();
        chk("w85_one_cycle", 32'(dout_valid), 32'd0);

        // Enable gap of 3 cycles mid-word with 2 pulses: dropped but counted.
        en = 1'b1;
        tick(1'b0); tick(1'b1); tick(1'b0);
        en = 1'b0;
        tick(1'b0); tick(1'b1); tick(1'b1);
        en = 1'b1;
        tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1);
        chk("gap_not_yet", 32'(dout_valid), 32'd0);
        tick(1'b0);
        chk("gap_valid", 32'(dout_valid), 32'd1);
        chk("gap_dout", 32'(dout), 32'h42);
        chk("gap_cnt", 32'(pulse_cnt), 32'd7);
        en = 1'b0;
        step();
        chk("gap_popped", 32'(dout_valid), 32'd0);

        // Consumer stalled: two 0xFF words held, third completion overflows.
        en = 1'b1;
        dout_ready = 1'b0;
        word(8'hFF);
        word(8'hFF);
        chk("stall_no_ovf", 32'(overflow), 32'd0);
        word(8'hFF);
        chk("stall_ovf", 32'(overflow), 32'd1);
        chk("stall_cnt", 32'(pulse_cnt), 32'd31);
        en = 1'b0;
        dout_ready = 1'b1;
        chk("stall_head1", 32'(dout), 32'hFF);
        step();
        chk("stall_valid2", 32'(dout_valid), 32'd1);
        chk("stall_head2", 32'(dout), 32'hFF);
        step();
        chk("stall_drained", 32'(dout_valid), 32'd0);
        chk("stall_ovf_sticky", 32'(overflow), 32'd1);

        // Reset, then full FIFO with a pop coinciding with the 3rd completion.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_ovf", 32'(overflow), 32'd0);
        chk("rst2_cnt", 32'(pulse_cnt), 32'd0);
        en = 1'b1;
        dout_ready = 1'b0;
        word(8'h01);
        word(8'h80);
        for (int i = 0; i < 7; i++) tick(i >= 2 && i <= 5);
        dout_ready = 1'b1;
        tick(1'b0);
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        chk("pp_head2", 32'(dout), 32'h80);
        en = 1'b0;
        step();
        chk("pp_valid3", 32'(dout_valid), 32'd1);
        chk("pp_head3", 32'(dout), 32'h3C);
        step();
        chk("pp_drained", 32'(dout_valid), 32'd0);
        chk("pp_cnt", 32'(pulse_cnt), 32'd6);

        // Saturation: 20 pulses on a 4-bit counter stop at 15.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick(1'b1);
        chk("sat4_at15", 32'(pulse_cnt4), 32'd15);
        for (int i = 0; i < 5; i++) tick(1'b1);
        chk("sat4_hold", 32'(pulse_cnt4), 32'd15);
        chk("sat16_cnt", 32'(pulse_cnt), 32'd20);

        // Reset mid-word with one word buffered discards everything.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        en = 1'b1;
        dout_ready = 1'b0;
        word(8'h03);
        chk("mid_buffered", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 5; i++) tick(1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_cnt", 32'(pulse_cnt), 32'd0);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        word(8'h80);
        chk("fresh_valid", 32'(dout_valid), 32'd1);
        chk("fresh_dout", 32'(dout), 32'h80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
